// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single processor-memory port between instruction fetch (icache)
//   and the LSQ data port. Data wins by default; after STARVE_LIMIT consecutive
//   denied icache cycles the icache takes priority for one grant. Load tags
//   accepted by memory are recorded with their owner so returning data can be
//   steered back to the requester that issued the load.
//
// Ports
//   clock_i, reset_i          system clock, asynchronous active-high reset
//   icache_command_i/addr_i   icache request (BUS_NONE/BUS_LOAD)
//   data_command_i/addr_i     LSQ request (BUS_NONE/BUS_LOAD/BUS_STORE)
//   data_wdata_i              LSQ store data
//   mem2proc_response_i       tag accepted this cycle, 0 = rejected
//   mem2proc_data_i/tag_i     returning load data and tag (tag 0 = none)
//   proc2mem_command_o/addr_o/data_o   command driven to memory
//   icache_response_o/tag_o/data_o     icache-side response and return
//   data_response_o/tag_o/rdata_o      LSQ-side response and return
//   outstanding_loads_o       number of valid owner-table entries
//   unexpected_tag_o          registered pulse: return tag with no owner

module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [1:0]      icache_command_i,
    input  logic [XLEN-1:0] icache_addr_i,
    input  logic [1:0]      data_command_i,
    input  logic [XLEN-1:0] data_addr_i,
    input  logic [63:0]     data_wdata_i,
    input  logic [3:0]      mem2proc_response_i,
    input  logic [63:0]     mem2proc_data_i,
    input  logic [3:0]      mem2proc_tag_i,
    output logic [1:0]      proc2mem_command_o,
    output logic [XLEN-1:0] proc2mem_addr_o,
    output logic [63:0]     proc2mem_data_o,
    output logic [3:0]      icache_response_o,
    output logic [3:0]      icache_tag_o,
    output logic [63:0]     icache_data_o,
    output logic [3:0]      data_response_o,
    output logic [3:0]      data_tag_o,
    output logic [63:0]     data_rdata_o,
    output logic [4:0]      outstanding_loads_o,
    output logic            unexpected_tag_o
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;   // 0 = icache, 1 = data
    logic [SC_W-1:0]     starve_q, starve_d;
    logic [4:0]          outstanding_q, outstanding_d;
    logic                unexpected_q, unexpected_d;

    logic icache_req, data_req;
    logic grant_icache, grant_data;
    logic alloc;
    logic ret_hit;
    logic ret_owner;

    assign icache_req = (icache_command_i != BUS_NONE);
    assign data_req   = (data_command_i != BUS_NONE);

    // Grants are forced off during reset so nothing reaches memory while the
    // owner table is being cleared.
    assign grant_data   = !reset_i && data_req && (!icache_req || (starve_q < STARVE_MAX));
    assign grant_icache = !reset_i && !grant_data && icache_req;

    always_comb begin
        proc2mem_command_o = BUS_NONE;
        proc2mem_addr_o    = '0;
        proc2mem_data_o    = '0;
        if (grant_data) begin
            proc2mem_command_o = data_command_i;
            proc2mem_addr_o    = data_addr_i;
            proc2mem_data_o    = data_wdata_i;
        end else if (grant_icache) begin
            proc2mem_command_o = icache_command_i;
            proc2mem_addr_o    = icache_addr_i;
        end
    end

    assign icache_response_o = grant_icache ? mem2proc_response_i : 4'd0;
    assign data_response_o   = grant_data   ? mem2proc_response_i : 4'd0;

    // Routing uses the owner as it stood before this edge, so a tag that is
    // returned and reallocated in the same cycle still goes to its old owner.
    assign ret_hit   = !reset_i && (mem2proc_tag_i != 4'd0) && valid_q[mem2proc_tag_i];
    assign ret_owner = owner_q[mem2proc_tag_i];

    assign icache_tag_o  = (ret_hit && !ret_owner) ? mem2proc_tag_i : 4'd0;
    assign data_tag_o    = (ret_hit &&  ret_owner) ? mem2proc_tag_i : 4'd0;
    assign icache_data_o = (icache_tag_o != 4'd0) ? mem2proc_data_i : 64'd0;
    assign data_rdata_o  = (data_tag_o   != 4'd0) ? mem2proc_data_i : 64'd0;

    // Stores are accepted by memory but never return data, so only loads
    // take an owner entry.
    assign alloc = (grant_data || grant_icache) && (proc2mem_command_o == BUS_LOAD)
                   && (mem2proc_response_i != 4'd0);

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit) begin
            valid_d[mem2proc_tag_i] = 1'b0;
        end
        // Applied after the clear so a same-cycle reallocation keeps the entry.
        if (alloc) begin
            valid_d[mem2proc_response_i] = 1'b1;
            owner_d[mem2proc_response_i] = grant_data;
        end
    end

    assign outstanding_d = outstanding_q + 5'(alloc) - 5'(ret_hit);
    assign unexpected_d  = (mem2proc_tag_i != 4'd0) && !valid_q[mem2proc_tag_i];

    always_comb begin
        starve_d = starve_q;
        if (icache_req && !grant_icache) begin
            if (starve_q < STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (!icache_req || (mem2proc_response_i != 4'd0)) begin
            starve_d = '0;
        end
        // Granted but rejected by memory: hold, icache keeps its priority.
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q       <= '0;
            owner_q       <= '0;
            starve_q      <= '0;
            outstanding_q <= '0;
            unexpected_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            owner_q       <= owner_d;
            starve_q      <= starve_d;
            outstanding_q <= outstanding_d;
            unexpected_q  <= unexpected_d;
        end
    end

    assign outstanding_loads_o = outstanding_q;
    assign unexpected_tag_o    = unexpected_q;

    // BUS_STORE is named for readability of the command encoding only.
    logic unused_store;
    assign unused_store = ^BUS_STORE;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic        clock, reset;
    logic [1:0]  icache_command, data_command;
    logic [31:0] icache_addr, data_addr;
    logic [63:0] data_wdata, mem2proc_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data, icache_data, data_rdata;
    logic [3:0]  icache_response, icache_tag, data_response, data_tag;
    logic [4:0]  outstanding_loads;
    logic        unexpected_tag;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clock_i             (clock),
        .reset_i             (reset),
        .icache_command_i    (icache_command),
        .icache_addr_i       (icache_addr),
        .data_command_i      (data_command),
        .data_addr_i         (data_addr),
        .data_wdata_i        (data_wdata),
        .mem2proc_response_i (mem2proc_response),
        .mem2proc_data_i     (mem2proc_data),
        .mem2proc_tag_i      (mem2proc_tag),
        .proc2mem_command_o  (proc2mem_command),
        .proc2mem_addr_o     (proc2mem_addr),
        .proc2mem_data_o     (proc2mem_data),
        .icache_response_o   (icache_response),
        .icache_tag_o        (icache_tag),
        .icache_data_o       (icache_data),
        .data_response_o     (data_response),
        .data_tag_o          (data_tag),
        .data_rdata_o        (data_rdata),
        .outstanding_loads_o (outstanding_loads),
        .unexpected_tag_o    (unexpected_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        icache_command = BUS_NONE; icache_addr = '0;
        data_command = BUS_NONE; data_addr = '0; data_wdata = '0;
        mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    endtask

    // Advance one edge; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        icache_command = BUS_LOAD; icache_addr = 32'h40;
        mem2proc_response = 4'd3; mem2proc_tag = 4'd3;
        cyc(); #1;
        checks++; if (proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL reset_cmd got %0d exp 0", proc2mem_command); end
        checks++; if (icache_response !== 4'd0) begin errors++; $display("FAIL reset_iresp got %0d exp 0", icache_response); end
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL reset_outst got %0d exp 0", outstanding_loads); end
        checks++; if (unexpected_tag !== 1'b0) begin errors++; $display("FAIL reset_unexp got %0b exp 0", unexpected_tag); end
        idle();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_icache_only();
        do_reset();
        icache_command = BUS_LOAD; icache_addr = 32'h100; mem2proc_response = 4'd3;
        #1;
        checks++; if (proc2mem_addr !== 32'h100) begin errors++; $display("FAIL t1_addr got %h exp 100", proc2mem_addr); end
        checks++; if (proc2mem_command !== BUS_LOAD) begin errors++; $display("FAIL t1_cmd got %0d exp 1", proc2mem_command); end
        checks++; if (icache_response !== 4'd3) begin errors++; $display("FAIL t1_iresp got %0d exp 3", icache_response); end
        checks++; if (data_response !== 4'd0) begin errors++; $display("FAIL t1_dresp got %0d exp 0", data_response); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd1) begin errors++; $display("FAIL t1_outst1 got %0d exp 1", outstanding_loads); end
        mem2proc_tag = 4'd3; mem2proc_data = 64'hAB;
        #1;
        checks++; if (icache_tag !== 4'd3) begin errors++; $display("FAIL t1_itag got %0d exp 3", icache_tag); end
        checks++; if (icache_data !== 64'hAB) begin errors++; $display("FAIL t1_idata got %h exp ab", icache_data); end
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t1_dtag got %0d exp 0", data_tag); end
        checks++; if (data_rdata !== 64'd0) begin errors++; $display("FAIL t1_drdata got %h exp 0", data_rdata); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t1_outst0 got %0d exp 0", outstanding_loads); end
        checks++; if (unexpected_tag !== 1'b0) begin errors++; $display("FAIL t1_unexp got %0b exp 0", unexpected_tag); end
    endtask

    task automatic test_starvation();
        logic exp_icache;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            icache_command = BUS_LOAD; icache_addr = 32'h300;
            data_command = BUS_STORE; data_addr = 32'h400; data_wdata = 64'h1;
            mem2proc_response = 4'(i + 1);
            exp_icache = ((i % 5) == 4);
            #1;
            checks++;
            if (proc2mem_addr !== (exp_icache ? 32'h300 : 32'h400)) begin
                errors++; $display("FAIL t2_addr cycle %0d got %h exp_icache %0b", i, proc2mem_addr, exp_icache);
            end
            checks++;
            if (icache_response !== (exp_icache ? 4'(i + 1) : 4'd0)) begin
                errors++; $display("FAIL t2_iresp cycle %0d got %0d exp_icache %0b", i, icache_response, exp_icache);
            end
            checks++;
            if (data_response !== (exp_icache ? 4'd0 : 4'(i + 1))) begin
                errors++; $display("FAIL t2_dresp cycle %0d got %0d exp_icache %0b", i, data_response, exp_icache);
            end
            cyc();
        end
        idle();
        // Icache loads accepted as tags 5 and 10; data stores are not recorded.
        checks++; if (outstanding_loads !== 5'd2) begin errors++; $display("FAIL t2_outst got %0d exp 2", outstanding_loads); end
    endtask

    task automatic test_store();
        do_reset();
        data_command = BUS_STORE; data_addr = 32'h200; data_wdata = 64'h55; mem2proc_response = 4'd5;
        #1;
        checks++; if (proc2mem_data !== 64'h55) begin errors++; $display("FAIL t3_pdata got %h exp 55", proc2mem_data); end
        checks++; if (proc2mem_command !== BUS_STORE) begin errors++; $display("FAIL t3_cmd got %0d exp 2", proc2mem_command); end
        checks++; if (data_response !== 4'd5) begin errors++; $display("FAIL t3_dresp got %0d exp 5", data_response); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t3_outst got %0d exp 0", outstanding_loads); end
        mem2proc_tag = 4'd5; mem2proc_data = 64'h99;
        #1;
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t3_dtag got %0d exp 0", data_tag); end
        checks++; if (icache_tag !== 4'd0) begin errors++; $display("FAIL t3_itag got %0d exp 0", icache_tag); end
        cyc();
        idle();
        checks++; if (unexpected_tag !== 1'b1) begin errors++; $display("FAIL t3_unexp got %0b exp 1", unexpected_tag); end
        cyc();
        checks++; if (unexpected_tag !== 1'b0) begin errors++; $display("FAIL t3_unexp_clr got %0b exp 0", unexpected_tag); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        data_command = BUS_LOAD; data_addr = 32'h10; mem2proc_response = 4'd7;
        cyc();
        idle();
        icache_command = BUS_LOAD; icache_addr = 32'h20; mem2proc_response = 4'd8;
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd2) begin errors++; $display("FAIL t4_outst2 got %0d exp 2", outstanding_loads); end
        mem2proc_tag = 4'd8; mem2proc_data = 64'h88;
        #1;
        checks++; if (icache_tag !== 4'd8) begin errors++; $display("FAIL t4_itag got %0d exp 8", icache_tag); end
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t4_dtag0 got %0d exp 0", data_tag); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd1) begin errors++; $display("FAIL t4_outst1 got %0d exp 1", outstanding_loads); end
        mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
        #1;
        checks++; if (data_tag !== 4'd7) begin errors++; $display("FAIL t4_dtag got %0d exp 7", data_tag); end
        checks++; if (data_rdata !== 64'h77) begin errors++; $display("FAIL t4_drdata got %h exp 77", data_rdata); end
        checks++; if (icache_tag !== 4'd0) begin errors++; $display("FAIL t4_itag0 got %0d exp 0", icache_tag); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t4_outst0 got %0d exp 0", outstanding_loads); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        data_command = BUS_LOAD; data_addr = 32'h10; mem2proc_response = 4'd7;
        cyc();
        idle();
        icache_command = BUS_LOAD; icache_addr = 32'h30; mem2proc_response = 4'd7;
        mem2proc_tag = 4'd7; mem2proc_data = 64'h70;
        #1;
        checks++; if (data_tag !== 4'd7) begin errors++; $display("FAIL t5_dtag got %0d exp 7", data_tag); end
        checks++; if (data_rdata !== 64'h70) begin errors++; $display("FAIL t5_drdata got %h exp 70", data_rdata); end
        checks++; if (icache_tag !== 4'd0) begin errors++; $display("FAIL t5_itag0 got %0d exp 0", icache_tag); end
        checks++; if (icache_response !== 4'd7) begin errors++; $display("FAIL t5_iresp got %0d exp 7", icache_response); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd1) begin errors++; $display("FAIL t5_outst1 got %0d exp 1", outstanding_loads); end
        mem2proc_tag = 4'd7; mem2proc_data = 64'h71;
        #1;
        checks++; if (icache_tag !== 4'd7) begin errors++; $display("FAIL t5_itag got %0d exp 7", icache_tag); end
        checks++; if (icache_data !== 64'h71) begin errors++; $display("FAIL t5_idata got %h exp 71", icache_data); end
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t5_dtag0 got %0d exp 0", data_tag); end
        cyc();
        idle();
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t5_outst0 got %0d exp 0", outstanding_loads); end
        checks++; if (unexpected_tag !== 1'b0) begin errors++; $display("FAIL t5_unexp got %0b exp 0", unexpected_tag); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int t = 2; t <= 4; t++) begin
            data_command = BUS_LOAD; data_addr = 32'(t * 16); mem2proc_response = 4'(t);
            cyc();
        end
        idle();
        checks++; if (outstanding_loads !== 5'd3) begin errors++; $display("FAIL t6_outst3 got %0d exp 3", outstanding_loads); end
        icache_command = BUS_LOAD; icache_addr = 32'h500;
        mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t6_outst_rst got %0d exp 0", outstanding_loads); end
        checks++; if (proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL t6_cmd_rst got %0d exp 0", proc2mem_command); end
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t6_dtag_rst got %0d exp 0", data_tag); end
        checks++; if (data_rdata !== 64'd0) begin errors++; $display("FAIL t6_drdata_rst got %h exp 0", data_rdata); end
        idle();
        cyc();
        reset = 1'b0;
        cyc();
        mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
        #1;
        checks++; if (data_tag !== 4'd0) begin errors++; $display("FAIL t6_dtag_old got %0d exp 0", data_tag); end
        cyc();
        idle();
        checks++; if (unexpected_tag !== 1'b1) begin errors++; $display("FAIL t6_unexp got %0b exp 1", unexpected_tag); end
        checks++; if (outstanding_loads !== 5'd0) begin errors++; $display("FAIL t6_outst_after got %0d exp 0", outstanding_loads); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_icache_only();
        test_starvation();
        test_store();
        test_out_of_order();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
